// File: rtl/wb2axi_bridge.sv
// wb2axi_bridge: Wishbone-classic single-beat slave to AXI4 master bridge.
// Writes issue AW and W together and may be posted with a bounded number of
// B responses outstanding; reads wait for posted writes to drain first.
module wb2axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter bit POSTED_WR  = 1'b1,
    parameter int MAX_WR_OUT = 4,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    // Wishbone slave side
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [DATA_WIDTH-1:0] wb_dat,
    input  logic [STRB_W-1:0]     wb_sel,
    input  logic                  wb_we,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    output logic [DATA_WIDTH-1:0] wb_rdt,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  wr_err,
    input  logic                  wr_err_clr,
    // AXI4 write address
    output logic [ID_WIDTH-1:0]   M_AXI_awid,
    output logic [ADDR_WIDTH-1:0] M_AXI_awaddr,
    output logic [7:0]            M_AXI_awlen,
    output logic [2:0]            M_AXI_awsize,
    output logic [1:0]            M_AXI_awburst,
    output logic [2:0]            M_AXI_awprot,
    output logic                  M_AXI_awvalid,
    input  logic                  M_AXI_awready,
    // AXI4 write data
    output logic [DATA_WIDTH-1:0] M_AXI_wdata,
    output logic [STRB_W-1:0]     M_AXI_wstrb,
    output logic                  M_AXI_wlast,
    output logic                  M_AXI_wvalid,
    input  logic                  M_AXI_wready,
    // AXI4 write response
    input  logic [ID_WIDTH-1:0]   M_AXI_bid,
    input  logic [1:0]            M_AXI_bresp,
    input  logic                  M_AXI_bvalid,
    output logic                  M_AXI_bready,
    // AXI4 read address
    output logic [ID_WIDTH-1:0]   M_AXI_arid,
    output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [7:0]            M_AXI_arlen,
    output logic [2:0]            M_AXI_arsize,
    output logic [1:0]            M_AXI_arburst,
    output logic [2:0]            M_AXI_arprot,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    // AXI4 read data
    input  logic [ID_WIDTH-1:0]   M_AXI_rid,
    input  logic [DATA_WIDTH-1:0] M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rlast,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready
);

    localparam int               CNT_W     = $clog2(MAX_WR_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WR_OUT);
    localparam logic [2:0]       AXI_SIZE  = 3'($clog2(STRB_W));
    localparam logic [1:0]       RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_RESP, RD_DRAIN, RD_ADDR, RD_DATA
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [CNT_W-1:0]      out_cnt;
    logic                  bready_q;
    logic                  cyc_lost;   // core abandoned the cycle; swallow its completion

    logic req, accept_wr, accept_rd;
    logic aw_done, w_done, wr_issue_done;
    logic b_hs, cnt_inc, cnt_dec, keep_pulse;
    logic unused_inputs;

    assign req           = wb_cyc & wb_stb & ~wb_ack & ~wb_err;
    assign accept_wr     = (state == IDLE) & req & wb_we & (out_cnt < CNT_MAX);
    assign accept_rd     = (state == IDLE) & req & ~wb_we;
    // A channel is done once its valid has dropped or is handshaking now.
    assign aw_done       = ~M_AXI_awvalid | M_AXI_awready;
    assign w_done        = ~M_AXI_wvalid | M_AXI_wready;
    assign wr_issue_done = (state == WR_ISSUE) & aw_done & w_done;
    assign b_hs          = M_AXI_bvalid & M_AXI_bready;
    assign cnt_inc       = POSTED_WR & wr_issue_done;
    assign cnt_dec       = POSTED_WR & b_hs;
    assign keep_pulse    = wb_cyc & ~cyc_lost;

    assign M_AXI_bready  = POSTED_WR ? (out_cnt != '0) : bready_q;

    assign M_AXI_awid    = '0;
    assign M_AXI_awaddr  = adr_q;
    assign M_AXI_awlen   = 8'd0;
    assign M_AXI_awsize  = AXI_SIZE;
    assign M_AXI_awburst = 2'b01;
    assign M_AXI_awprot  = 3'd0;
    assign M_AXI_wlast   = 1'b1;
    assign M_AXI_arid    = '0;
    assign M_AXI_araddr  = adr_q;
    assign M_AXI_arlen   = 8'd0;
    assign M_AXI_arsize  = AXI_SIZE;
    assign M_AXI_arburst = 2'b01;
    assign M_AXI_arprot  = 3'd0;

    assign unused_inputs = ^{M_AXI_bid, M_AXI_rid, M_AXI_rlast};

    // Transaction FSM: request capture, AXI channel valids/readies, completion pulses.
    always_ff @(posedge ACLK) begin
        // NOTE: state is updated with <= so every branch sees the pre-edge values.
        if (!ARESETN) begin
            state         <= IDLE;
            adr_q         <= '0;
            M_AXI_wdata   <= '0;
            M_AXI_wstrb   <= '0;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b0;
            bready_q      <= 1'b0;
            wb_rdt        <= '0;
            wb_ack        <= 1'b0;
            wb_err        <= 1'b0;
            cyc_lost      <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            if (state != IDLE && !wb_cyc) begin
                cyc_lost <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept_wr || accept_rd) begin
                        adr_q       <= wb_adr;
                        M_AXI_wdata <= wb_dat;
                        M_AXI_wstrb <= wb_sel;
                        cyc_lost    <= 1'b0;
                    end
                    if (accept_wr) begin
                        M_AXI_awvalid <= 1'b1;
                        M_AXI_wvalid  <= 1'b1;
                        state         <= WR_ISSUE;
                    end else if (accept_rd) begin
                        // Nothing outstanding: skip the drain wait to save a cycle.
                        if (out_cnt == '0) begin
                            M_AXI_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end else begin
                            state <= RD_DRAIN;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (M_AXI_awready) M_AXI_awvalid <= 1'b0;
                    if (M_AXI_wready)  M_AXI_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        if (POSTED_WR) begin
                            wb_ack <= keep_pulse;
                            state  <= IDLE;
                        end else begin
                            bready_q <= 1'b1;
                            state    <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        bready_q <= 1'b0;
                        wb_ack   <= keep_pulse & (M_AXI_bresp == RESP_OKAY);
                        wb_err   <= keep_pulse & (M_AXI_bresp != RESP_OKAY);
                        state    <= IDLE;
                    end
                end
                RD_DRAIN: begin
                    if (out_cnt == '0) begin
                        M_AXI_arvalid <= 1'b1;
                        state         <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_arready) begin
                        M_AXI_arvalid <= 1'b0;
                        M_AXI_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_rvalid) begin
                        M_AXI_rready <= 1'b0;
                        wb_rdt       <= M_AXI_rdata;
                        wb_ack       <= keep_pulse & (M_AXI_rresp == RESP_OKAY);
                        wb_err       <= keep_pulse & (M_AXI_rresp != RESP_OKAY);
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Posted-write counter: +1 on issue completion, -1 on B handshake, both cancel.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            out_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            out_cnt <= out_cnt + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            out_cnt <= out_cnt - 1'b1;
        end
    end

    // Sticky posted-write error flag; a new error wins over a clear.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_err <= 1'b0;
        end else if (cnt_dec && (M_AXI_bresp != RESP_OKAY)) begin
            wr_err <= 1'b1;
        end else if (wr_err_clr) begin
            wr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb2axi_bridge.sv
// tb_wb2axi_bridge: directed bench for wb2axi_bridge. One posted instance
// (MAX_WR_OUT=2) and one non-posted instance share the AXI-side stimulus;
// each has its own Wishbone cyc/stb so only one is active at a time.
module tb_wb2axi_bridge;

    logic        ACLK, ARESETN;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb, np_cyc, np_stb, wr_err_clr;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    // posted instance outputs
    logic [31:0] wb_rdt, awaddr, wdata, araddr;
    logic        wb_ack, wb_err, wr_err, awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, arburst;

    // non-posted instance outputs
    logic [31:0] np_rdt, np_awaddr, np_wdata, np_araddr;
    logic        np_ack, np_err, np_wr_err, np_awvalid, np_wvalid, np_wlast, np_bready, np_arvalid, np_rready;
    logic [3:0]  np_awid, np_arid, np_wstrb;
    logic [7:0]  np_awlen, np_arlen;
    logic [2:0]  np_awsize, np_awprot, np_arsize, np_arprot;
    logic [1:0]  np_awburst, np_arburst;

    int n_cmp, n_bad, cyc;

    wb2axi_bridge #(.POSTED_WR(1'b1), .MAX_WR_OUT(2)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_rdt(wb_rdt), .wb_ack(wb_ack),
        .wb_err(wb_err), .wr_err(wr_err), .wr_err_clr(wr_err_clr),
        .M_AXI_awid(awid), .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awsize(awsize),
        .M_AXI_awburst(awburst), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast), .M_AXI_wvalid(wvalid),
        .M_AXI_wready(wready), .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid),
        .M_AXI_bready(bready), .M_AXI_arid(arid), .M_AXI_araddr(araddr), .M_AXI_arlen(arlen),
        .M_AXI_arsize(arsize), .M_AXI_arburst(arburst), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid),
        .M_AXI_arready(arready), .M_AXI_rid(rid), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp),
        .M_AXI_rlast(rlast), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
    );

    wb2axi_bridge #(.POSTED_WR(1'b0)) dut_np (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .wb_adr(wb_adr), .wb_dat(wb_dat), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(np_cyc), .wb_stb(np_stb), .wb_rdt(np_rdt), .wb_ack(np_ack),
        .wb_err(np_err), .wr_err(np_wr_err), .wr_err_clr(wr_err_clr),
        .M_AXI_awid(np_awid), .M_AXI_awaddr(np_awaddr), .M_AXI_awlen(np_awlen), .M_AXI_awsize(np_awsize),
        .M_AXI_awburst(np_awburst), .M_AXI_awprot(np_awprot), .M_AXI_awvalid(np_awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(np_wdata), .M_AXI_wstrb(np_wstrb), .M_AXI_wlast(np_wlast), .M_AXI_wvalid(np_wvalid),
        .M_AXI_wready(wready), .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid),
        .M_AXI_bready(np_bready), .M_AXI_arid(np_arid), .M_AXI_araddr(np_araddr), .M_AXI_arlen(np_arlen),
        .M_AXI_arsize(np_arsize), .M_AXI_arburst(np_arburst), .M_AXI_arprot(np_arprot), .M_AXI_arvalid(np_arvalid),
        .M_AXI_arready(arready), .M_AXI_rid(rid), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp),
        .M_AXI_rlast(rlast), .M_AXI_rvalid(rvalid), .M_AXI_rready(np_rready)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wb_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_we  = we;
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
    endtask

    task automatic wb_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
    endtask

    // Cycles until wb_ack is seen; 0 means the budget ran out.
    task automatic wait_ack(input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (wb_ack) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic b_beat(input logic [1:0] resp);
        bvalid = 1'b1;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    // Full posted write with ready channels; ack expected two cycles after request.
    task automatic posted_write(input string tag, input logic [31:0] adr, input logic [31:0] dat);
        wb_req(1'b1, adr, dat, 4'hF);
        wait_ack(10, cyc);
        check(tag, cyc, 2);
        wb_idle();
        tick();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        ARESETN = 1'b0; wr_err_clr = 1'b0;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; np_cyc = 1'b0; np_stb = 1'b0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00; bid = 4'h5;
        rvalid = 1'b0; rresp = 2'b00; rdata = '0; rid = 4'h3; rlast = 1'b1;
        tick(); tick();

        // ---- reset values
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid",  wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready",  bready, 0);
        check("rst_rready",  rready, 0);
        check("rst_ack",     wb_ack, 0);
        check("rst_err",     wb_err, 0);
        check("rst_wr_err",  wr_err, 0);
        check("rst_rdt",     wb_rdt, 0);
        check("rst_awaddr",  awaddr, 0);
        check("rst_wdata",   wdata, 0);
        check("rst_out_cnt", dut.out_cnt, 0);
        check("rst_np_bready", np_bready, 0);
        ARESETN = 1'b1;
        tick();

        // ---- posted write, all ready
        wb_req(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
        tick();
        check("t1_awvalid_c1", awvalid, 1);
        check("t1_wvalid_c1",  wvalid, 1);
        check("t1_awaddr",     awaddr, 32'h1000);
        check("t1_wdata",      wdata, 32'hDEAD_BEEF);
        check("t1_wstrb",      wstrb, 4'hF);
        check("t1_wlast",      wlast, 1);
        check("t1_awsize",     awsize, 3'd2);
        check("t1_awburst",    awburst, 2'b01);
        check("t1_awid",       awid, 0);
        check("t1_ack_c1",     wb_ack, 0);
        tick();
        check("t1_ack_c2",     wb_ack, 1);
        check("t1_awvalid_c2", awvalid, 0);
        check("t1_out_cnt1",   dut.out_cnt, 1);
        check("t1_bready",     bready, 1);
        wb_idle();
        tick();
        check("t1_ack_single", wb_ack, 0);
        b_beat(2'b00);
        check("t1_out_cnt0",   dut.out_cnt, 0);
        check("t1_bready0",    bready, 0);
        check("t1_wr_err",     wr_err, 0);

        // ---- split handshake: AW at edge 1, W three edges later
        wready = 1'b0;
        wb_req(1'b1, 32'h1004, 32'h1122_3344, 4'h3);
        tick();
        check("t2_both_valid", {awvalid, wvalid}, 2'b11);
        tick();
        check("t2_aw_dropped", {awvalid, wvalid}, 2'b01);
        check("t2_ack_c2",     wb_ack, 0);
        tick(); tick();
        check("t2_w_held",     wvalid, 1);
        check("t2_wdata_hold", wdata, 32'h1122_3344);
        check("t2_ack_c4",     wb_ack, 0);
        wready = 1'b1;
        tick();
        check("t2_ack",        wb_ack, 1);
        check("t2_wvalid0",    wvalid, 0);
        wb_idle();
        tick();
        check("t2_ack_single", wb_ack, 0);
        b_beat(2'b00);
        check("t2_out_cnt0",   dut.out_cnt, 0);

        // ---- backpressure with MAX_WR_OUT=2 and no B
        posted_write("t3_w1_lat", 32'h1100, 32'hA0A0_A0A0);
        posted_write("t3_w2_lat", 32'h1104, 32'hB1B1_B1B1);
        check("t3_out_cnt2", dut.out_cnt, 2);
        wb_req(1'b1, 32'h1108, 32'hC2C2_C2C2, 4'hF);
        repeat (4) tick();
        check("t3_stall_awvalid", awvalid, 0);
        check("t3_stall_ack",     wb_ack, 0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("t3_out_cnt_dec", dut.out_cnt, 1);
        wait_ack(10, cyc);
        check("t3_w3_lat",    cyc, 2);
        check("t3_w3_awaddr", awaddr, 32'h1108);
        check("t3_out_cnt_full", dut.out_cnt, 2);
        wb_idle();
        bvalid = 1'b1;
        tick(); tick();
        bvalid = 1'b0;
        check("t3_drained", dut.out_cnt, 0);

        // ---- increment and B decrement on the same edge
        posted_write("t4_wa_lat", 32'h1200, 32'h0000_0001);
        wb_req(1'b1, 32'h1204, 32'h0000_0002, 4'hF);
        tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("t4_ack",        wb_ack, 1);
        check("t4_cnt_steady", dut.out_cnt, 1);
        wb_idle();
        tick();
        b_beat(2'b00);
        check("t4_cnt0", dut.out_cnt, 0);

        // ---- write-then-read ordering
        posted_write("t5_w_lat", 32'h1300, 32'h1357_9BDF);
        wb_req(1'b0, 32'h2000, 32'h0, 4'hF);
        tick();
        check("t5_ar_blocked_a", arvalid, 0);
        tick(); tick();
        check("t5_ar_blocked_b", arvalid, 0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("t5_ar_after_b", arvalid, 0);
        tick();
        check("t5_arvalid",  arvalid, 1);
        check("t5_araddr",   araddr, 32'h2000);
        tick();
        check("t5_rready",   rready, 1);
        check("t5_ar_drop",  arvalid, 0);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check("t5_ack",      wb_ack, 1);
        check("t5_err",      wb_err, 0);
        check("t5_rdt",      wb_rdt, 32'hCAFE_F00D);
        wb_idle();
        tick();

        // ---- read latency with SLVERR
        wb_req(1'b0, 32'h2004, 32'h0, 4'hF);
        tick();
        check("t6_arvalid_c1", arvalid, 1);
        check("t6_araddr",     araddr, 32'h2004);
        tick();
        check("t6_rready_c2",  rready, 1);
        rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        check("t6_err_c3",     wb_err, 1);
        check("t6_no_ack",     wb_ack, 0);
        check("t6_rdt",        wb_rdt, 32'h0BAD_F00D);
        wb_idle();
        tick();
        check("t6_err_single", wb_err, 0);

        // ---- posted DECERR sets sticky wr_err; set beats clear
        posted_write("t7_w_lat", 32'h1400, 32'h2468_ACE0);
        b_beat(2'b11);
        check("t7_wr_err_set",  wr_err, 1);
        tick();
        check("t7_wr_err_hold", wr_err, 1);
        wr_err_clr = 1'b1;
        tick();
        wr_err_clr = 1'b0;
        check("t7_wr_err_clr",  wr_err, 0);
        posted_write("t7_w2_lat", 32'h1404, 32'h2468_ACE1);
        bvalid = 1'b1; bresp = 2'b11; wr_err_clr = 1'b1;
        tick();
        bvalid = 1'b0; bresp = 2'b00; wr_err_clr = 1'b0;
        check("t7_set_wins", wr_err, 1);
        wr_err_clr = 1'b1;
        tick();
        wr_err_clr = 1'b0;
        check("t7_clr_again", wr_err, 0);

        // ---- abort: cyc drops while W is stalled
        wready = 1'b0;
        wb_req(1'b1, 32'h1500, 32'h7777_7777, 4'hF);
        tick();
        wb_idle();
        tick(); tick();
        wready = 1'b1;
        tick();
        check("t8_no_ack",   wb_ack, 0);
        check("t8_wvalid0",  wvalid, 0);
        check("t8_out_cnt1", dut.out_cnt, 1);
        tick();
        check("t8_no_ack_b", wb_ack, 0);
        b_beat(2'b00);
        check("t8_out_cnt0", dut.out_cnt, 0);

        // ---- non-posted: SLVERR then OKAY
        wb_we = 1'b1; wb_adr = 32'h3000; wb_dat = 32'h0F0F_0F0F; wb_sel = 4'hF;
        np_cyc = 1'b1; np_stb = 1'b1;
        tick();
        check("t9_np_valids", {np_awvalid, np_wvalid}, 2'b11);
        tick();
        check("t9_np_bready", np_bready, 1);
        check("t9_np_noack",  np_ack, 0);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        check("t9_np_err",     np_err, 1);
        check("t9_np_ack0",    np_ack, 0);
        check("t9_np_bready0", np_bready, 0);
        check("t9_posted_untouched", wr_err, 0);
        np_cyc = 1'b0; np_stb = 1'b0;
        tick();
        check("t9_np_err_single", np_err, 0);
        np_cyc = 1'b1; np_stb = 1'b1;
        tick(); tick();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("t9_np_ok_ack", np_ack, 1);
        check("t9_np_ok_err", np_err, 0);
        np_cyc = 1'b0; np_stb = 1'b0;
        tick();

        // ---- reset during WR_ISSUE with state built up
        posted_write("t10_wa_lat", 32'h1600, 32'h0000_1600);
        b_beat(2'b11);
        posted_write("t10_wb_lat", 32'h1604, 32'h0000_1604);
        awready = 1'b0; wready = 1'b0;
        wb_req(1'b1, 32'h4000, 32'h55AA_55AA, 4'hC);
        tick();
        check("t10_pre_awvalid", awvalid, 1);
        check("t10_pre_wr_err",  wr_err, 1);
        ARESETN = 1'b0;
        tick();
        check("t10_awvalid", awvalid, 0);
        check("t10_wvalid",  wvalid, 0);
        check("t10_awaddr",  awaddr, 0);
        check("t10_wdata",   wdata, 0);
        check("t10_wstrb",   wstrb, 0);
        check("t10_out_cnt", dut.out_cnt, 0);
        check("t10_bready",  bready, 0);
        check("t10_wr_err",  wr_err, 0);
        check("t10_rdt",     wb_rdt, 0);
        check("t10_ack",     wb_ack, 0);
        ARESETN = 1'b1;
        wb_idle();
        awready = 1'b1; wready = 1'b1;
        tick();
        posted_write("t10_recover_lat", 32'h1700, 32'h0000_1700);
        check("t10_recover_cnt", dut.out_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb2axi_bridge.md
# wb2axi_bridge

Parametrised Wishbone-classic to AXI4 master bridge for SERV-class data buses. It converts single-beat Wishbone reads and writes into AXI4 AR/R and AW/W/B transactions. AW and W issue concurrently. Writes can be posted, with a bounded number outstanding. AXI error responses are reported back to the core. The bridge sits between the core's data port and the AXI interconnect master port.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides (32 or 64); STRB_W = DATA_WIDTH/8
- ID_WIDTH, 4, AXI ID width; awid and arid are driven with constant 0
- POSTED_WR, 1, 1: ack writes at AW+W completion; 0: ack at B
- MAX_WR_OUT, 4, maximum number of posted writes awaiting B (1..15)
- ACLK  in  1  clock
- ARESETN  in  1  reset; **synchronous, active-low**
- wb_adr  in  ADDR_WIDTH  address
- wb_dat  in  DATA_WIDTH  write data
- wb_sel  in  STRB_W  byte selects
- wb_we  in  1  write enable
- wb_cyc, wb_stb  in  1 each  request qualifiers
- wb_rdt  out  DATA_WIDTH  read data, registered
- wb_ack  out  1  one-cycle completion pulse
- wb_err  out  1  one-cycle error completion pulse (replaces ack)
- wr_err  out  1  sticky flag: posted write got non-OKAY bresp
- wr_err_clr  in  1  clears wr_err
- M_AXI_awid/awaddr/awlen/awsize/awburst/awprot  out  ID/ADDR/8/3/2/3  awlen=0, awsize=log2(STRB_W), awburst=INCR, awprot=0
- M_AXI_awvalid  out  1; M_AXI_awready  in  1
- M_AXI_wdata/wstrb/wlast  out  DATA/STRB_W/1  wlast=1 whenever wvalid=1
- M_AXI_wvalid  out  1; M_AXI_wready  in  1
- M_AXI_bid/bresp  in  ID/2; M_AXI_bvalid  in  1; M_AXI_bready  out  1
- M_AXI_arid/araddr/arlen/arsize/arburst/arprot  out  same constants as AW
- M_AXI_arvalid  out  1; M_AXI_arready  in  1
- M_AXI_rid/rdata/rresp/rlast  in  ID/DATA/2/1; M_AXI_rvalid  in  1; M_AXI_rready  out  1

## Operation
- **States:** IDLE, WR_ISSUE, WR_RESP, RD_DRAIN, RD_ADDR, RD_DATA.
- **Acceptance:** a request is accepted in IDLE when wb_cyc & wb_stb, and the ack/err pulse is not high in that cycle. On acceptance, adr/dat/sel are latched.
- **Write accept:**
  - A write is accepted only if out_cnt < MAX_WR_OUT; otherwise the bridge stalls in IDLE.
  - On accept, go to WR_ISSUE and set awvalid=1 and wvalid=1 together.
  - Each valid drops independently on its own handshake. WR_ISSUE exits once both handshakes have occurred, whether simultaneous or in either order.
- **Write completion, POSTED_WR=1:**
  - On exit from WR_ISSUE: out_cnt+1, wb_ack pulse, return to IDLE.
  - bready = (out_cnt != 0). Each B handshake decrements out_cnt.
  - bresp != OKAY sets wr_err.
- **Write completion, POSTED_WR=0:**
  - WR_ISSUE -> WR_RESP with bready=1.
  - On B handshake: wb_ack if bresp=OKAY, else wb_err. Return to IDLE. out_cnt is unused.
- **Read:**
  - Accept goes to RD_DRAIN, which waits until out_cnt=0. This preserves write-then-read ordering.
  - RD_DRAIN -> RD_ADDR with arvalid=1, held until arready.
  - RD_ADDR -> RD_DATA with rready=1. On R handshake: wb_rdt <= rdata; wb_ack if rresp=OKAY, else wb_err. Return to IDLE.
- **out_cnt:** width ceil(log2(MAX_WR_OUT+1)). An increment and a B decrement in the same cycle leave it unchanged. It never over- or underflows.
- **wr_err:** set takes priority over wr_err_clr in the same cycle.
- **Abort:** if wb_cyc drops mid-transaction, the AXI transaction still completes, but the ack/err pulse is suppressed. The bridge returns to IDLE normally.
- bid, rid and rlast are ignored.

## Timing
- **Reset values:** all valids, bready, rready, wb_ack, wb_err and wr_err = 0; wb_rdt = 0; out_cnt = 0; state = IDLE. awaddr/araddr/wdata/wstrb = 0.
- **Reset mid-operation:** everything returns to the reset values at the next edge. In-flight AXI transactions are abandoned.
- **Write latency** (ready=1, posted): request sampled at edge 0; aw/wvalid high in cycle 1; both handshake at edge 1; wb_ack high in cycle 2.
- **Read latency:** arvalid in cycle 1; with rvalid one cycle after AR, wb_ack is high in cycle 3.
- A new request can be accepted the cycle after the ack pulse.
- Valids are never retracted before their handshake, and payloads are stable while valid=1.

## Test plan
- **Posted write, ready=1:** write 0x1000 <- 0xDEADBEEF, sel=0xF. Expect aw/w in cycle 1, wb_ack in cycle 2, out_cnt 1 -> 0 after bvalid.
- **Split handshake:** awready high 3 cycles before wready. Expect awvalid to drop first and a single wb_ack after the W handshake.
- **Backpressure:** MAX_WR_OUT=2, bvalid held low, issue 3 writes. Expect 2 acks; the third stalls until a B handshake, then acks.
- **Ordering:** one posted write pending B, then a read to 0x2000. Expect arvalid to stay 0 until the B handshake; wb_rdt = rdata; wb_ack.
- **Errors:**
  - rresp=SLVERR -> wb_err pulse, no ack.
  - Posted bresp=DECERR -> wr_err=1 until wr_err_clr.
  - POSTED_WR=0 with bresp=SLVERR -> wb_err.
- **Reset and simultaneous count:** ARESETN low during WR_ISSUE -> all outputs return to reset values next edge. A separate check covers a simultaneous accept and B handshake, where out_cnt must stay unchanged.
